// File: rtl/ms_count_if.sv
// Bus between the minesweeper board logic and the adjacent-mine counter.
// zero_map exists only when MS_COUNT_ZERO_MAP_EN is defined.
interface ms_count_if;
    logic [63:0] mine;
    logic        gen_done;
    logic [5:0]  rd_addr;
    logic [3:0]  rd_count;
    logic        rd_mine;
    logic        cell_valid;
    logic [5:0]  cell_idx;
    logic [3:0]  cell_count;
    logic        busy;
    logic        count_done;
`ifdef MS_COUNT_ZERO_MAP_EN
    logic [63:0] zero_map;
`endif

    modport master (
        output mine, gen_done, rd_addr,
        input  rd_count, rd_mine, cell_valid, cell_idx, cell_count, busy, count_done
`ifdef MS_COUNT_ZERO_MAP_EN
        , input zero_map
`endif
    );

    modport slave (
        input  mine, gen_done, rd_addr,
        output rd_count, rd_mine, cell_valid, cell_idx, cell_count, busy, count_done
`ifdef MS_COUNT_ZERO_MAP_EN
        , output zero_map
`endif
    );
endinterface

// File: rtl/ms_count.sv
// Adjacent-mine counter: scans the latched 8x8 mine map one cell per clock into a 64x4 count file.
// Optional zero-count seed mask (zero_map) enabled by defining MS_COUNT_ZERO_MAP_EN.
//
// state | meaning
// IDLE  | waiting for a gen_done rising edge after reset
// SCAN  | writing count of cell idx_q each clock
// DONE  | full board valid; a new rise restarts the scan
module ms_count #(
    parameter logic [3:0] MINE_CODE = 4'hF
) (
    input logic      clk,
    input logic      n_reset,
    ms_count_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t      state_q, state_d;
    logic        gen_done_q;
    logic [63:0] mine_q, mine_d;
    logic [5:0]  idx_q, idx_d;
    logic [3:0]  counts_q [64];
    logic        cell_valid_q, cell_valid_d;
    logic [5:0]  cell_idx_q, cell_idx_d;
    logic [3:0]  cell_count_q, cell_count_d;
    logic        busy_q, busy_d;
    logic        count_done_q, count_done_d;
    logic        wr_en;
    logic [3:0]  nbr_n;
    logic [3:0]  wr_val;
    logic        rise;
`ifdef MS_COUNT_ZERO_MAP_EN
    logic [63:0] zero_map_q, zero_map_d;
`endif

    // Out-of-board neighbours are skipped, so edge columns never wrap into the adjacent row.
    function automatic logic [3:0] nbr_count(input logic [63:0] m, input logic [5:0] c);
        logic [3:0] n;
        int         r;
        int         k;
        n = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                r = int'(c[5:3]) + dr;
                k = int'(c[2:0]) + dc;
                if ((dr != 0 || dc != 0) && r >= 0 && r < 8 && k >= 0 && k < 8)
                    n = n + {3'b000, m[6'(r * 8 + k)]};
            end
        end
        return n;
    endfunction

    assign rise   = bus.gen_done & ~gen_done_q;
    assign nbr_n  = nbr_count(mine_q, idx_q);
    assign wr_val = mine_q[idx_q] ? MINE_CODE : nbr_n;

    always_comb begin
        state_d      = state_q;
        mine_d       = mine_q;
        idx_d        = idx_q;
        cell_valid_d = 1'b0;
        cell_idx_d   = cell_idx_q;
        cell_count_d = cell_count_q;
        busy_d       = busy_q;
        count_done_d = count_done_q;
        wr_en        = 1'b0;
`ifdef MS_COUNT_ZERO_MAP_EN
        zero_map_d   = zero_map_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (rise) begin
                    mine_d       = bus.mine;
                    idx_d        = '0;
                    state_d      = SCAN;
                    busy_d       = 1'b1;
                    count_done_d = 1'b0;
`ifdef MS_COUNT_ZERO_MAP_EN
                    zero_map_d   = '0;
`endif
                end
            end
            SCAN: begin
                wr_en        = 1'b1;
                cell_valid_d = 1'b1;
                cell_idx_d   = idx_q;
                cell_count_d = wr_val;
                idx_d        = idx_q + 6'd1;
`ifdef MS_COUNT_ZERO_MAP_EN
                zero_map_d[idx_q] = ~mine_q[idx_q] && (nbr_n == 4'd0);
`endif
                if (idx_q == 6'd63) begin
                    state_d      = DONE;
                    busy_d       = 1'b0;
                    count_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q      <= IDLE;
            gen_done_q   <= 1'b0;
            mine_q       <= '0;
            idx_q        <= '0;
            cell_valid_q <= 1'b0;
            cell_idx_q   <= '0;
            cell_count_q <= '0;
            busy_q       <= 1'b0;
            count_done_q <= 1'b0;
            for (int i = 0; i < 64; i++) counts_q[i] <= '0;
`ifdef MS_COUNT_ZERO_MAP_EN
            zero_map_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            gen_done_q   <= bus.gen_done;
            mine_q       <= mine_d;
            idx_q        <= idx_d;
            cell_valid_q <= cell_valid_d;
            cell_idx_q   <= cell_idx_d;
            cell_count_q <= cell_count_d;
            busy_q       <= busy_d;
            count_done_q <= count_done_d;
            if (wr_en) counts_q[idx_q] <= wr_val;
`ifdef MS_COUNT_ZERO_MAP_EN
            zero_map_q   <= zero_map_d;
`endif
        end
    end

    assign bus.rd_count   = counts_q[bus.rd_addr];
    assign bus.rd_mine    = mine_q[bus.rd_addr];
    assign bus.cell_valid = cell_valid_q;
    assign bus.cell_idx   = cell_idx_q;
    assign bus.cell_count = cell_count_q;
    assign bus.busy       = busy_q;
    assign bus.count_done = count_done_q;
`ifdef MS_COUNT_ZERO_MAP_EN
    assign bus.zero_map   = zero_map_q;
`endif

endmodule

// File: doc/ms_count.md
Name: ms_count

Overview:
- Consumer of the 64-bit mine map produced by the minesweeper generator.
- On each completed generation, scans the 8x8 board one cell per clock and computes each cell's adjacent-mine count.
- Stores the counts in an internal 64x4 register file with a combinational read port for the display/reveal logic.
- Also streams each result as it is computed.
- Cell index = row*8 + col; row 0 is bits 7:0.

Parameters:
- MINE_CODE, 4'hF, value stored and streamed for a cell that is itself a mine.

Ports:
- clk  input  1  system clock; all state on rising edge
- n_reset  input  1  synchronous, active-low reset
- mine  input  64  mine map from generator; bit i set = mine in cell i
- gen_done  input  1  generator completion flag; a scan starts on its rising edge
- rd_addr  input  6  read-port cell index
- rd_count  output  4  combinational count of cell rd_addr (0..8 or MINE_CODE)
- rd_mine  output  1  latched mine bit of cell rd_addr
- cell_valid  output  1  one-cycle strobe: cell_idx/cell_count valid
- cell_idx  output  6  index of the cell just written
- cell_count  output  4  count just written
- busy  output  1  high while scanning
- count_done  output  1  high once a full scan completes; held until next scan start or reset
- zero_map  output  64  optional, see below

Behaviour:
- Reset (n_reset=0 at a clock edge):
  - state=IDLE; gen_done_q, mine_q, idx, all 64 counts cleared to 0.
  - cell_valid=0, cell_idx=0, cell_count=0, busy=0, count_done=0.
  - rd_count=0, rd_mine=0 for any address.
- Trigger: rise = gen_done & ~gen_done_q; gen_done_q registers gen_done every cycle. Because gen_done_q resets to 0, gen_done held high through reset counts as a rise at the first edge after reset release.
- State IDLE or DONE, rise at edge T0:
  - mine_q<=mine, idx<=0, state<=SCAN, busy<=1, count_done<=0.
- SCAN, edge Tk (k=1..64), cell c=k-1:
  - n = number of set mine_q bits among the in-board 8-neighbours of c.
  - No wrap: col 0 has no left neighbours, col 7 no right, row 0 no upper, row 7 no lower.
  - counts[c] <= mine_q[c] ? MINE_CODE : n (4-bit, max 8).
  - cell_valid<=1, cell_idx<=c, cell_count<= the same value; idx<=idx+1.
- At edge T64: state<=DONE, busy<=0, count_done<=1.
  - cell_valid is high for the 64 cycles following T1..T64 and low otherwise.
  - count_done is first high in the cycle after T64. Total latency from trigger edge to count_done = 64 clocks.
- Input changes:
  - A rise while in SCAN is ignored; no restart, no queueing.
  - mine changes during SCAN have no effect (mine_q is latched at T0).
- Read port is combinational from the register file and mine_q. It is valid for cells already written; full-board valid when count_done=1.
- Reset mid-scan: immediate return to IDLE with all state cleared, as for reset.

Optional Feature:
- Macro MS_COUNT_ZERO_MAP_EN.
- Defined: zero_map output present, reset 0, cleared at T0. Bit c is set at edge Tk (c=k-1) iff the written count is 0 and the cell is not a mine. Used as the seed mask for flood-fill reveal.
- Undefined: zero_map port and logic absent; all other behaviour identical.

Test Plan:
- Reset, mine=0, gen_done 0->1 -> 64 cell_valid strobes with cell_idx 0..63 in order, all counts 0; busy high 64 cycles; count_done high 64 clocks after trigger edge; zero_map=64'hFFFF_FFFF_FFFF_FFFF (if enabled).
- mine=64'h1 -> rd_count(0)=F; rd_count(1)=rd_count(8)=rd_count(9)=1; all others 0; rd_mine(0)=1.
- Single mine at cell 27 -> cells 18,19,20,26,28,34,35,36 read 1; cell 27 reads F; others 0.
- Mine at cell 7 (row-edge wrap check) -> cells 6,14,15 read 1; cell 8 reads 0.
- mine=~64'h200 -> rd_count(9)=8; every other cell reads F.
- Start a scan, pulse gen_done again at cell 20 -> ignored, scan finishes at 64. Then start a new scan and assert n_reset=0 at cell 30 -> next cycle busy=0, count_done=0, rd_count(any)=0. Release reset with gen_done held high -> new scan starts at the first edge.
